// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/csb/sdi and turns rw+addr+data frames into one-cycle register-bus strobes.
// Optional build macro SPI_SLAVE_BURST_EN adds auto-incrementing multi-byte write/read bursts.
module spi_slave #(
  parameter int PACKAGE_SIZE = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    csb,
  input  logic                    sdi,
  output logic                    sdo,
  output logic                    sdo_oe,
  output logic [PACKAGE_SIZE-2:0] addr,
  output logic [PACKAGE_SIZE-1:0] wr_data,
  output logic                    wr_en,
  output logic                    rd_en,
  input  logic [PACKAGE_SIZE-1:0] rd_data,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int CW = $clog2(PACKAGE_SIZE);
  localparam int AW = PACKAGE_SIZE - 1;

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RWADDR, WRITE, READ, WAIT_CSB} state_t;

  state_t                  r_state, w_next;
  logic [SYNC_STAGES-1:0]  r_sclk_sync, r_csb_sync, r_sdi_sync;
  logic                    r_sclk_d;
  logic [CW-1:0]           r_cnt;
  logic [PACKAGE_SIZE-1:0] r_shift;
  logic [AW-1:0]           r_addr;
  logic [PACKAGE_SIZE-1:0] r_wr_data;
  logic                    r_wr_en, r_rd_en, r_sdo, r_frame_err, r_byte_done;
  logic [RD_LATENCY-1:0]   r_rd_pipe;

  logic                    w_sclk, w_csb, w_sdi, w_rise, w_fall, w_last, w_abort;
  logic [PACKAGE_SIZE-1:0] w_shift_in;

  // NOTE: synchronizer flops carry no reset; forcing csb high here would let a
  // reset in mid-frame resume the frame instead of waiting for a real csb high.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
    r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
    r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
    r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb      = r_csb_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_fall     = ~w_sclk & r_sclk_d;
  assign w_last     = (r_cnt == CW'(PACKAGE_SIZE - 1));
  assign w_shift_in = {r_shift[PACKAGE_SIZE-2:0], w_sdi};

  // csb high between burst bytes is a clean end of frame, not a truncation.
  assign w_abort = w_csb && !r_byte_done &&
                   (r_state == RWADDR || r_state == WRITE || r_state == READ);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (!w_csb) w_next = RWADDR;
      RWADDR: begin
        if (w_csb)                 w_next = IDLE;
        else if (w_rise && w_last) w_next = w_shift_in[PACKAGE_SIZE-1] ? READ : WRITE;
      end
      WRITE, READ: begin
        if (w_csb)                            w_next = IDLE;
        else if (w_rise && w_last && !BURST)  w_next = WAIT_CSB;
      end
      WAIT_CSB: if (w_csb) w_next = IDLE;
      default:  w_next = WAIT_CSB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later ones in
  // this block take priority, which sets the strobe defaults and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_CSB;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_pipe   <= '0;
      r_sdo       <= 1'b1;
      r_frame_err <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= w_abort;
      r_rd_pipe   <= RD_LATENCY'({r_rd_pipe, r_rd_en});
      if (r_state != READ) r_sdo <= 1'b1;

      case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_byte_done <= 1'b0;
        end
        RWADDR: if (w_rise && !w_csb) begin
          r_shift <= w_shift_in;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_addr  <= w_shift_in[AW-1:0];
            r_rd_en <= w_shift_in[PACKAGE_SIZE-1];
          end
        end
        WRITE: if (w_rise && !w_csb) begin
          r_shift <= w_shift_in;
          r_cnt   <= r_cnt + CW'(1);
          if (r_byte_done) begin
            r_addr      <= r_addr + AW'(1);
            r_byte_done <= 1'b0;
          end
          if (w_last) begin
            r_cnt       <= '0;
            r_wr_data   <= w_shift_in;
            r_wr_en     <= 1'b1;
            r_byte_done <= BURST;
          end
        end
        READ: begin
          if (w_fall) begin
            r_sdo   <= r_shift[PACKAGE_SIZE-1];
            r_shift <= {r_shift[PACKAGE_SIZE-2:0], 1'b0};
          end
          if (w_rise && !w_csb) begin
            r_cnt       <= r_cnt + CW'(1);
            r_byte_done <= 1'b0;
            if (w_last) begin
              r_cnt <= '0;
              if (BURST) begin
                r_addr      <= r_addr + AW'(1);
                r_rd_en     <= 1'b1;
                r_byte_done <= 1'b1;
              end
            end
          end
        end
        default: r_cnt <= '0;
      endcase

      if (r_rd_pipe[RD_LATENCY-1]) r_shift <= rd_data;
    end
  end

  assign sdo       = r_sdo;
  assign sdo_oe    = (r_state == READ);
  assign busy      = (r_state != IDLE);
  assign addr      = r_addr;
  assign wr_data   = r_wr_data;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: two instances (RD_LATENCY 1 and 2) share one SPI master;
// expected strobes come from a frame-level model, read bytes from a reference memory.
module tb_spi_slave;

  localparam int HALF = 4;  // clk cycles per sclk half period (8x oversampling)

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic       is_wr;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, csb = 1'b1, sdi = 1'b0;
  logic       sdo0, sdo_oe0, wr_en0, rd_en0, busy0, frame_err0;
  logic       sdo1, sdo_oe1, wr_en1, rd_en1, busy1, frame_err1;
  logic [6:0] addr0, addr1;
  logic [7:0] wr_data0, wr_data1, rd_data0, rd_data1;

  always #5 clk = ~clk;

  spi_slave #(.PACKAGE_SIZE(8), .SYNC_STAGES(2), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .sdi(sdi),
    .sdo(sdo0), .sdo_oe(sdo_oe0), .addr(addr0), .wr_data(wr_data0),
    .wr_en(wr_en0), .rd_en(rd_en0), .rd_data(rd_data0), .busy(busy0),
    .frame_err(frame_err0));

  spi_slave #(.PACKAGE_SIZE(8), .SYNC_STAGES(2), .RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .sdi(sdi),
    .sdo(sdo1), .sdo_oe(sdo_oe1), .addr(addr1), .wr_data(wr_data1),
    .wr_en(wr_en1), .rd_en(rd_en1), .rd_data(rd_data1), .busy(busy1),
    .frame_err(frame_err1));

  // Register file behind the DUTs: read data valid only in its latency slot, noise otherwise.
  logic [7:0] regs    [128];
  logic [7:0] ref_mem [128];
  logic [7:0] lat_a, lat_b1, lat_b2;

  always @(posedge clk) begin
    lat_a  <= rd_en0 ? regs[addr0] : 8'($urandom);
    lat_b1 <= rd_en1 ? regs[addr1] : 8'($urandom);
    lat_b2 <= lat_b1;
    if (wr_en0) regs[addr0] <= wr_data0;
  end
  assign rd_data0 = lat_a;
  assign rd_data1 = lat_b2;

  int   checks = 0, failures = 0;
  int   exp_strobes = 0, exp_ferr = 0;
  int   strobe_cyc0 = 0, strobe_cyc1 = 0, ferr_cyc0 = 0, ferr_cyc1 = 0;
  exp_t exp_q[$];
  logic [7:0] wbuf [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe cycle pops one expected access and compares both instances.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en0 || rd_en0) strobe_cyc0++;
    if (wr_en1 || rd_en1) strobe_cyc1++;
    if (frame_err0) ferr_cyc0++;
    if (frame_err1) ferr_cyc1++;
    if (wr_en0 || rd_en0 || wr_en1 || rd_en1) begin
      check("strobe_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_en_l1", 32'(wr_en0), 32'(e.is_wr));
        check("rd_en_l1", 32'(rd_en0), 32'(!e.is_wr));
        check("addr_l1",  32'(addr0),  32'(e.addr));
        check("wr_en_l2", 32'(wr_en1), 32'(e.is_wr));
        check("rd_en_l2", 32'(rd_en1), 32'(!e.is_wr));
        check("addr_l2",  32'(addr1),  32'(e.addr));
        if (e.is_wr) begin
          check("wr_data_l1", 32'(wr_data0), 32'(e.data));
          check("wr_data_l2", 32'(wr_data1), 32'(e.data));
        end
      end
    end
  end

  // One SPI frame (mode 0). stop_bit >= 0 truncates it, rst_bit >= 0 pulses rst at that bit.
  task automatic spi_frame(input logic rw, input logic [6:0] a, input int nbytes,
                           input int stop_bit, input int rst_bit, input int gap);
    int         nbits, nev;
    bit         aborted, live;
    logic [7:0] hdr, got0, got1, exp_byte;
    nbits   = 8 + 8 * nbytes;
    hdr     = {rw, a};
    aborted = (stop_bit >= 0) && (stop_bit < nbits);
    live    = !aborted && (rst_bit < 0);
    if (aborted) begin
      nbits = stop_bit;
      exp_ferr++;
    end
    if (live) begin
      // A burst read also prefetches the address after its last byte.
      if (rw) nev = BURST ? nbytes + 1 : 1;
      else    nev = BURST ? nbytes : 1;
      for (int k = 0; k < nev; k++) begin
        logic [6:0] ak;
        ak = a + 7'(k);
        exp_q.push_back('{!rw, ak, rw ? 8'h00 : wbuf[k]});
        exp_strobes++;
        if (!rw) ref_mem[ak] = wbuf[k];
      end
    end
    got0 = 8'h00;
    got1 = 8'h00;
    csb  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) sdi = hdr[7-i];
      else       sdi = wbuf[(i-8)/8][7-((i-8)%8)];
      if (i == rst_bit) rst = 1'b1;
      repeat (HALF) @(negedge clk);
      rst = 1'b0;
      if (i >= 8) begin
        int k;
        bit en;
        k  = (i - 8) / 8;
        en = live && rw && (k == 0 || BURST);
        check("sdo_oe_l1", 32'(sdo_oe0), 32'(en));
        check("sdo_oe_l2", 32'(sdo_oe1), 32'(en));
        got0 = {got0[6:0], sdo0};
        got1 = {got1[6:0], sdo1};
        if ((i - 8) % 8 == 7 && live) begin
          exp_byte = en ? ref_mem[a + 7'(k)] : 8'hFF;
          check("rd_byte_l1", 32'(got0), 32'(exp_byte));
          check("rd_byte_l2", 32'(got1), 32'(exp_byte));
        end
      end
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    csb = 1'b1;
    sdi = 1'b0;
    repeat (gap) @(negedge clk);
    check("busy_idle_l1",  32'(busy0),   32'(0));
    check("busy_idle_l2",  32'(busy1),   32'(0));
    check("sdo_idle",      32'(sdo0),    32'(1));
    check("sdo_oe_idle",   32'(sdo_oe0), 32'(0));
    check("frame_err_l1",  32'(ferr_cyc0), 32'(exp_ferr));
    check("frame_err_l2",  32'(ferr_cyc1), 32'(exp_ferr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      regs[i]   <= v;
    end
    ref_mem[7'h2A] = 8'h3C;
    regs[7'h2A]   <= 8'h3C;

    // Reset values; the block comes out of reset waiting for csb high, so busy is set.
    repeat (5) @(negedge clk);
    check("rst_sdo",       32'(sdo0),       32'(1));
    check("rst_sdo_oe",    32'(sdo_oe0),    32'(0));
    check("rst_addr",      32'(addr0),      32'(0));
    check("rst_wr_data",   32'(wr_data0),   32'(0));
    check("rst_wr_en",     32'(wr_en0),     32'(0));
    check("rst_rd_en",     32'(rd_en0),     32'(0));
    check("rst_frame_err", 32'(frame_err0), 32'(0));
    check("rst_busy",      32'(busy0),      32'(1));
    check("rst_busy_l2",   32'(busy1),      32'(1));
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_after_rst", 32'(busy0), 32'(0));

    wbuf[0] = 8'hA5;
    spi_frame(1'b0, 7'h15, 1, -1, -1, 8);
    spi_frame(1'b1, 7'h2A, 1, -1, -1, 8);

    spi_frame(1'b0, 7'h01, 1, 5, -1, 8);
    wbuf[0] = 8'hFF;
    spi_frame(1'b0, 7'h01, 1, -1, -1, 8);

    wbuf[0] = 8'h77;
    spi_frame(1'b0, 7'h10, 1, -1, 11, 8);
    check("addr_after_midrst",    32'(addr0),    32'(0));
    check("wr_data_after_midrst", 32'(wr_data0), 32'(0));
    wbuf[0] = 8'h55;
    spi_frame(1'b0, 7'h10, 1, -1, -1, 8);

    wbuf[0] = 8'h11;
    spi_frame(1'b0, 7'h03, 1, -1, -1, 2 * HALF);
    wbuf[0] = 8'h22;
    spi_frame(1'b0, 7'h04, 1, -1, -1, 2 * HALF);

    spi_frame(1'b1, 7'h7F, 3, -1, -1, 8);

    for (int r = 0; r < 10; r++) begin
      wbuf[0] = 8'($urandom);
      spi_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 1, -1, -1, 6);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("strobe_cycles_l1",   32'(strobe_cyc0),  32'(exp_strobes));
    check("strobe_cycles_l2",   32'(strobe_cyc1),  32'(exp_strobes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the team's SPI master frame format: 1 rw bit + (PACKAGE_SIZE-1) address bits, then one PACKAGE_SIZE data byte, MSB first, csb active-low.
- SPI-side inputs are oversampled in the system clock domain. The block converts frames into single-cycle register-bus write/read strobes.
- Placed in front of a register file so the FPGA can be configured over SPI by an external host.

Parameters:
- PACKAGE_SIZE, 8, bits per byte; address width is PACKAGE_SIZE-1.
- SYNC_STAGES, 2, synchronizer flops on sclk, csb and sdi (minimum 2).
- RD_LATENCY, 1, clk cycles from rd_en to rd_data valid (1 or 2 only).

Ports:
- clk  in  1  system clock; must be at least 8x sclk.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master (asynchronous).
- csb  in  1  chip select, active low (asynchronous).
- sdi  in  1  serial data from master; master updates it on falling sclk.
- sdo  out  1  serial data to master; sampled by master on rising sclk.
- sdo_oe  out  1  output enable for sdo pad; high only in READ.
- addr  out  PACKAGE_SIZE-1  register address of the current access.
- wr_data  out  PACKAGE_SIZE  write data.
- wr_en  out  1  one-cycle write strobe.
- rd_en  out  1  one-cycle read request.
- rd_data  in  PACKAGE_SIZE  read data, valid RD_LATENCY cycles after rd_en.
- busy  out  1  high whenever state != IDLE.
- frame_err  out  1  one-cycle pulse on a truncated frame.

Behaviour:
- Reset (synchronous, active-high): sdo=1, sdo_oe=0, addr=0, wr_data=0, wr_en=0, rd_en=0, frame_err=0, bit counter=0. Next state is WAIT_CSB.
- Input conditioning: sclk, csb and sdi each pass through SYNC_STAGES flops. Rise and fall of sclk are detected with one extra register, so the edge event lags the pin by SYNC_STAGES+1 clk.
- Bit sampling: sdi is sampled on each detected sclk rise. sdo is updated on each detected sclk fall.
- States:
  - IDLE: sdo=1. Synced csb low -> RWADDR, counter=0.
  - RWADDR: shift in PACKAGE_SIZE bits on rises. The first bit is rw; the remaining bits are the address, MSB first.
    - On the last rise: latch addr.
    - rw=0 -> WRITE.
    - rw=1 -> pulse rd_en the next clk, capture rd_data into the shift register RD_LATENCY clk after rd_en, then -> READ.
  - WRITE: shift in PACKAGE_SIZE bits. On the last rise, load wr_data and pulse wr_en the next clk, then -> WAIT_CSB.
  - READ: sdo_oe=1.
    - On each fall, sdo takes the shift register MSB and the register shifts left.
    - The first fall in READ is the one that ends the address phase, so bit7 is presented before the master's first sampling rise.
    - After PACKAGE_SIZE rises -> WAIT_CSB.
  - WAIT_CSB: sdo=1, sdo_oe=0; sclk is ignored. Synced csb high -> IDLE.
- Synced csb rising in RWADDR, WRITE or READ before the byte completes:
  - pulse frame_err, go to IDLE;
  - no wr_en is issued;
  - an rd_en already issued is not retracted.
- Every wr_en/rd_en pulse is exactly 1 clk; at most one strobe per byte. addr is held stable from its latch until the next frame's address latch.
- Reset mid-frame: state goes to WAIT_CSB, so the remainder of the frame is ignored. A new frame is accepted only after csb has been seen high.
- Back-to-back frames: csb high for at least 2 clk (synced) is enough to return to IDLE and accept the next frame.
- Timing guarantee: with clk >= 8x sclk and RD_LATENCY <= 2, read data is loaded before the falling edge that launches bit7.

Optional Feature:
- Macro SPI_SLAVE_BURST_EN.
- Defined: after each data byte, if csb is still low, addr increments by 1, wrapping from 2^(PACKAGE_SIZE-1)-1 to 0, and the state stays WRITE or READ for another byte.
  - Write burst: one wr_en per byte.
  - Read burst: rd_en for the next address is issued on the last rise of the current byte, and data is loaded before the next fall.
- Not defined: after one data byte -> WAIT_CSB; any further sclk while csb is low is ignored and sdo stays 1.

Test Plan:
- Write frame rw=0, addr=0x15, data=0xA5 -> exactly one wr_en pulse with addr=0x15, wr_data=0xA5; rd_en never asserted; busy returns low after csb high.
- Read frame rw=1, addr=0x2A, rd_data=0x3C (RD_LATENCY=1 and 2) -> one rd_en with addr=0x2A; master captures 0x3C; sdo_oe high only during the data byte.
- Abort: csb raised after 5 address bits -> frame_err one pulse, no wr_en/rd_en; next full write frame (addr=0x01, data=0xFF) is accepted normally.
- rst asserted at data bit 3 of a write to 0x10 -> no wr_en; remaining bits ignored; after csb high, a write of 0x55 to 0x10 produces wr_en with 0x55.
- Two back-to-back writes (0x03<-0x11, 0x04<-0x22) with csb high for 1 sclk period between them -> two wr_en pulses carrying the correct pairs.
- SPI_SLAVE_BURST_EN: read burst from 0x7F, 3 bytes -> rd_en addresses 0x7F, 0x00, 0x01 in order; without the macro, only 0x7F is read and sdo stays 1.
